// File: rtl/osd_dii_pkg.sv
//------------------------------------------------------------------------------
// Module   : osd_dii_pkg
// Purpose  : Shared constants and types for the debug-interconnect arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package osd_dii_pkg;

    localparam int DII_FLIT_W = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } dii_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/osd_rr_select.sv
//------------------------------------------------------------------------------
// Module   : osd_rr_select
// Purpose  : Combinational find-first-set starting at a rotating index.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module osd_rr_select
    import osd_dii_pkg::*;
#(
    parameter int PORTS = 2
) (
    input  logic [PORTS-1:0]         req,
    input  logic [$clog2(PORTS)-1:0] ptr,
    output logic [$clog2(PORTS)-1:0] sel,
    output logic                     any
);

    localparam int PW = $clog2(PORTS);

    logic [PW-1:0] w_sel_hi;
    logic [PW-1:0] w_sel_lo;
    logic          w_hit_hi;

    // Lowest requester at or above ptr wins; otherwise wrap to the lowest below it.
    always_comb begin
        w_sel_hi = '0;
        w_sel_lo = '0;
        w_hit_hi = 1'b0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i >= int'(ptr)) begin
                    w_hit_hi = 1'b1;
                    w_sel_hi = PW'(i);
                end else begin
                    w_sel_lo = PW'(i);
                end
            end
        end
    end

    assign sel = w_hit_hi ? w_sel_hi : w_sel_lo;
    assign any = |req;

endmodule

`default_nettype wire

// File: rtl/osd_dii_arbiter.sv
//------------------------------------------------------------------------------
// Module   : osd_dii_arbiter
// Purpose  : Packet-granular round-robin arbiter onto one registered DII port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module osd_dii_arbiter
    import osd_dii_pkg::*;
#(
    parameter int PORTS = 2,
    parameter int W     = DII_FLIT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PORTS*W-1:0]       in_data,
    input  logic [PORTS-1:0]         in_last,
    input  logic [PORTS-1:0]         in_valid,
    output logic [PORTS-1:0]         in_ready,
    output logic [W-1:0]             out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [$clog2(PORTS)-1:0] grant
);

    localparam int            GW          = $clog2(PORTS);
    localparam logic [GW-1:0] C_LAST_PORT = GW'(PORTS - 1);

    dii_arb_state_t r_state;
    dii_arb_state_t w_state_next;
    logic [GW-1:0]  r_ptr;
    logic [GW-1:0]  w_ptr_next;
    logic [GW-1:0]  r_grant;
    logic [GW-1:0]  w_grant_next;
    logic [GW-1:0]  w_sel;
    logic           w_any;
    logic           w_can_accept;
    logic           w_xfer;
    logic           w_in_last;
    logic [W-1:0]   w_in_data;
    logic [PORTS-1:0] w_in_ready;
    logic [W-1:0]   r_out_data;
    logic           r_out_last;
    logic           r_out_valid;

    osd_rr_select #(
        .PORTS (PORTS)
    ) u_rr_select (
        .req (in_valid),
        .ptr (r_ptr),
        .sel (w_sel),
        .any (w_any)
    );

    // Output stage can take a flit when empty or draining this cycle.
    assign w_can_accept = !r_out_valid || out_ready;
    assign w_in_data    = in_data[r_grant*W +: W];
    assign w_in_last    = in_last[r_grant];
    assign w_xfer       = (r_state == XFER) && in_valid[r_grant] && w_can_accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_grant <= w_grant_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_grant_next = r_grant;
        w_in_ready   = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_next = w_sel;
                    w_state_next = XFER;
                end
            end
            XFER: begin
                w_in_ready[r_grant] = w_can_accept;
                if (w_xfer && w_in_last) begin
                    w_ptr_next   = (r_grant == C_LAST_PORT) ? '0 : r_grant + 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // A load in the same cycle as a drain keeps valid high for full throughput.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_xfer) begin
            r_out_data  <= w_in_data;
            r_out_last  <= w_in_last;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == XFER);
    assign grant     = r_grant;

endmodule

`default_nettype wire
